// File: rtl/decred_nonce_collector_pkg.sv
// Shared definitions for the Decred nonce collector: FSM state encoding and parameter defaults.
// NUMBER_OF_MACROS may be predefined by the build; otherwise it defaults to 4.
`ifndef NUMBER_OF_MACROS
`define NUMBER_OF_MACROS 4
`endif

package decred_nonce_collector_pkg;

  typedef logic [1:0] fsm_state_t;

  localparam fsm_state_t ST_IDLE  = 2'd0;
  localparam fsm_state_t ST_SETUP = 2'd1;
  localparam fsm_state_t ST_READ  = 2'd2;
  localparam fsm_state_t ST_PUSH  = 2'd3;

  localparam int         DEFAULT_NUM_MACROS  = `NUMBER_OF_MACROS;
  localparam logic [5:0] DEFAULT_RESULT_ADDR = 6'h3C;

endpackage

// File: rtl/decred_nonce_fifo.sv
// Synchronous show-ahead FIFO; the head word is presented while not empty and reads as zero when empty.
// A simultaneous push and pop on a full FIFO performs both.
module decred_nonce_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == {(AW + 1){1'b0}});
  assign full    = (count == (AW + 1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? {WIDTH{1'b0}} : mem[rd_ptr];

  // Storage array.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= {(AW + 1){1'b0}};
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/decred_nonce_collector.sv
// Collects nonces from the hash macro array: edge capture, round-robin arbiter, byte-serial read FSM.
// Optional macro-index tag on queued nonces is enabled by defining DECRED_NONCE_TAG_EN.
module decred_nonce_collector
  import decred_nonce_collector_pkg::*;
#(
  parameter int         NUM_MACROS  = DEFAULT_NUM_MACROS,
  parameter int         NONCE_BYTES = 4,
  parameter logic [5:0] RESULT_ADDR = DEFAULT_RESULT_ADDR,
  parameter int         FIFO_DEPTH  = 4
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic                     ENABLE,
  input  logic [NUM_MACROS-1:0]    DATA_AVAILABLE,
  output logic [NUM_MACROS-1:0]    MACRO_RD_SELECT,
  output logic [5:0]               HASH_ADDR,
  input  logic [7:0]               DATA_FROM_HASH,
  output logic                     NONCE_VALID,
  output logic [8*NONCE_BYTES-1:0] NONCE_DATA,
  input  logic                     NONCE_READY,
  output logic                     OVERFLOW,
  input  logic                     OVERFLOW_CLR,
`ifdef DECRED_NONCE_TAG_EN
  output logic [$clog2(NUM_MACROS)-1:0] NONCE_MACRO,
`endif
  output logic                     IRQ_OUT
);

  localparam int GW = $clog2(NUM_MACROS);
  localparam int BW = (NONCE_BYTES > 1) ? $clog2(NONCE_BYTES) : 1;
  localparam int DW = 8 * NONCE_BYTES;
`ifdef DECRED_NONCE_TAG_EN
  localparam int FW = DW + GW;
`else
  localparam int FW = DW;
`endif
  localparam logic [BW-1:0]         LAST_BYTE = BW'(NONCE_BYTES - 1);
  localparam logic [5:0]            LAST_ADDR = RESULT_ADDR + 6'(NONCE_BYTES - 1);
  localparam logic [NUM_MACROS-1:0] ONE_HOT0  = {{(NUM_MACROS - 1){1'b0}}, 1'b1};

  logic [NUM_MACROS-1:0] prev;
  logic [NUM_MACROS-1:0] rise;
  logic [NUM_MACROS-1:0] pending;
  logic [NUM_MACROS-1:0] clr_mask;
  logic [NUM_MACROS-1:0] select;
  fsm_state_t            state;
  logic [GW-1:0]         grant;
  logic [GW-1:0]         last_grant;
  logic [GW-1:0]         next_grant;
  logic                  arb_hit;
  int                    arb_idx;
  logic [BW-1:0]         byte_idx;
  logic [DW-1:0]         nonce;
  logic [5:0]            addr;
  logic                  overflow;
  logic                  irq;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [FW-1:0]         fifo_wdata;
  logic [FW-1:0]         fifo_rdata;

  assign rise      = DATA_AVAILABLE & ~prev;
  assign fifo_push = (state == ST_PUSH);
  assign fifo_pop  = NONCE_READY & ~fifo_empty;

  // prev ignores reset so flags already high at reset release never look like new results.
  always_ff @(posedge CLK) begin
    prev <= DATA_AVAILABLE;
  end

  // Pending is cleared when its grant enters SETUP.
  always_comb begin
    clr_mask = {NUM_MACROS{1'b0}};
    if (state == ST_SETUP) begin
      clr_mask = ONE_HOT0 << grant;
    end else begin
      clr_mask = {NUM_MACROS{1'b0}};
    end
  end

  // A rising edge in the same cycle as the clear wins.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      pending <= {NUM_MACROS{1'b0}};
    end else begin
      pending <= (pending & ~clr_mask) | rise;
    end
  end

  // Round-robin: first pending index strictly after last_grant, wrapping.
  always_comb begin
    next_grant = last_grant;
    arb_hit    = 1'b0;
    arb_idx    = 0;
    for (int k = 1; k <= NUM_MACROS; k++) begin
      arb_idx = int'(last_grant) + k;
      if (arb_idx >= NUM_MACROS) begin
        arb_idx = arb_idx - NUM_MACROS;
      end else begin
        arb_idx = arb_idx;
      end
      if (!arb_hit && pending[arb_idx[GW-1:0]]) begin
        arb_hit    = 1'b1;
        next_grant = arb_idx[GW-1:0];
      end else begin
        arb_hit    = arb_hit;
      end
    end
  end

  // Read sequencer. HASH_ADDR runs one byte ahead of the sample because the bus answers a cycle late.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state      <= ST_IDLE;
      grant      <= {GW{1'b0}};
      last_grant <= GW'(NUM_MACROS - 1);
      byte_idx   <= {BW{1'b0}};
      nonce      <= {DW{1'b0}};
      select     <= {NUM_MACROS{1'b0}};
      addr       <= 6'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ENABLE && arb_hit) begin
            grant  <= next_grant;
            select <= ONE_HOT0 << next_grant;
            addr   <= RESULT_ADDR;
            state  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          byte_idx <= {BW{1'b0}};
          if (addr != LAST_ADDR) begin
            addr <= addr + 6'd1;
          end
          state <= ST_READ;
        end
        ST_READ: begin
          nonce[{byte_idx, 3'b000} +: 8] <= DATA_FROM_HASH;
          if (addr != LAST_ADDR) begin
            addr <= addr + 6'd1;
          end
          if (byte_idx < LAST_BYTE) begin
            byte_idx <= byte_idx + BW'(1);
          end else begin
            select <= {NUM_MACROS{1'b0}};
            state  <= ST_PUSH;
          end
        end
        ST_PUSH: begin
          last_grant <= grant;
          state      <= ST_IDLE;
        end
        default: begin
          select <= {NUM_MACROS{1'b0}};
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky overflow: a dropped push beats a simultaneous clear.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      overflow <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (fifo_push && fifo_full && !fifo_pop) begin
        overflow <= 1'b1;
      end else if (OVERFLOW_CLR) begin
        overflow <= 1'b0;
      end
      irq <= ~fifo_empty;
    end
  end

`ifdef DECRED_NONCE_TAG_EN
  assign fifo_wdata  = {grant, nonce};
  assign NONCE_MACRO = fifo_rdata[FW-1:DW];
`else
  assign fifo_wdata  = nonce;
`endif

  decred_nonce_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RESET_N),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign MACRO_RD_SELECT = select;
  assign HASH_ADDR       = addr;
  assign NONCE_VALID     = ~fifo_empty;
  assign NONCE_DATA      = fifo_rdata[DW-1:0];
  assign OVERFLOW        = overflow;
  assign IRQ_OUT         = irq;

endmodule
